timed_decoder: RTL and testbench

- Registered, parametrised successor to the combinational one-hot decoder.
- Accepts select commands over a valid/ready handshake. Drives a one-hot output bus in one of four modes: level (latched), pulse (single cycle), hold (N+1 cycles), or scan (auto-rotating one-hot with programmable dwell).
- Sits between control logic (UART command parser, timers) and per-channel enables such as LED rows, chip selects and strobes.

---
 rtl/timed_decoder_pkg.sv | 41 ++++
 rtl/timed_decoder_dec.sv | 23 ++
 rtl/timed_decoder.sv | 144 ++++++++++++++
 tb/tb_timed_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/timed_decoder_pkg.sv
// Shared types and helpers for the timed one-hot decoder.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package timed_decoder_pkg;

    // Widest output bus the rotate helper supports; OUT_WIDTH must not exceed it.
    localparam int MAX_OUT_WIDTH = 1024;

    typedef enum logic [1:0] {
        LEVEL = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        SCAN  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEVEL = 2'd1,
        S_HOLD  = 2'd2,
        S_SCAN  = 2'd3
    } state_e;

    // Rotate the low 'width' bits of value left by one; bit width-1 wraps to bit 0.
    // Bits at or above 'width' come back as zero.
    function automatic logic [MAX_OUT_WIDTH-1:0] onehot_rotl(
        input logic [MAX_OUT_WIDTH-1:0] value,
        input int                       width
    );
        logic [MAX_OUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_OUT_WIDTH; i++) begin
            if (i == width - 1) begin
                r[0] = value[i];
            end else if (i < width - 1) begin
                r[i+1] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timed_decoder_dec.sv
// Combinational binary-to-one-hot decoder with enable, truncated to OUTPUT_SIZE lines.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs directly.
module timed_decoder_dec #(
    parameter int INPUT_SIZE  = 5,
    parameter int OUTPUT_SIZE = 2**INPUT_SIZE
) (
    input  logic [INPUT_SIZE-1:0]  sel,
    input  logic                   en,
    output logic [OUTPUT_SIZE-1:0] dec
);

    // One line high for the selected index; all zero when disabled or index beyond OUTPUT_SIZE.
    always_comb begin
        dec = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (en && (sel == INPUT_SIZE'(i))) begin
                dec[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timed_decoder.sv
// Registered one-hot decoder with level / pulse / hold / scan modes over valid/ready.
// Latency: accepted command shows on out from the accepting edge (one register stage).
// Backpressure: in_ready low during an active hold (until its last cycle) and while clear is high.
module timed_decoder
    import timed_decoder_pkg::*;
#(
    parameter int INPUT_SIZE = 5,
    parameter int OUT_WIDTH  = 2**INPUT_SIZE,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [INPUT_SIZE-1:0] in_sel,
    input  logic [HOLD_WIDTH-1:0] in_hold,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  busy,
    output logic                  err
);

    // OUT_WIDTH can be 2**INPUT_SIZE, so the compare needs one extra bit.
    localparam logic [INPUT_SIZE:0] OUT_LIMIT = OUT_WIDTH[INPUT_SIZE:0];

    state_e                  state_q, state_d;
    logic [OUT_WIDTH-1:0]    out_q, out_d;
    logic [HOLD_WIDTH-1:0]   cnt_q, cnt_d;
    logic [HOLD_WIDTH-1:0]   dwell_q, dwell_d;
    logic                    err_q, err_d;

    logic                    in_range;
    logic                    accept;
    logic [OUT_WIDTH-1:0]    sel_onehot;
    logic [MAX_OUT_WIDTH-1:0] out_ext;

    assign in_range = ({1'b0, in_sel} < OUT_LIMIT);

    timed_decoder_dec #(
        .INPUT_SIZE  (INPUT_SIZE),
        .OUTPUT_SIZE (OUT_WIDTH)
    ) u_dec (
        .sel (in_sel),
        .en  (in_range),
        .dec (sel_onehot)
    );

    // Hold refuses new work until its final cycle so back-to-back pulses still flow.
    assign in_ready = !rst && !clear && ((state_q != S_HOLD) || (cnt_q == '0));
    assign accept   = in_valid && in_ready;

    assign out  = out_q;
    assign err  = err_q;
    assign busy = (state_q != S_IDLE);

    // Zero-extended copy of the output so the package rotate helper can work on it.
    always_comb begin
        out_ext                = '0;
        out_ext[OUT_WIDTH-1:0] = out_q;
    end

    // Next-state: clear beats an accepted command, which beats hold/scan sequencing.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            out_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            if (!in_range) begin
                // Bad index: flag it and drop to idle whatever the mode.
                err_d   = 1'b1;
                state_d = S_IDLE;
                out_d   = '0;
                cnt_d   = '0;
            end else begin
                out_d = sel_onehot;
                unique case (mode_e'(in_mode))
                    LEVEL: begin
                        state_d = S_LEVEL;
                        cnt_d   = '0;
                    end
                    PULSE: begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                    HOLD: begin
                        state_d = S_HOLD;
                        cnt_d   = in_hold;
                    end
                    SCAN: begin
                        state_d = S_SCAN;
                        cnt_d   = in_hold;
                        dwell_d = in_hold;
                    end
                    default: ;
                endcase
            end
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        out_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_SCAN: begin
                    if (cnt_q == '0) begin
                        out_d = OUT_WIDTH'(onehot_rotl(out_ext, OUT_WIDTH));
                        cnt_d = dwell_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_timed_decoder.sv
// Directed bench for timed_decoder: a 32-line instance and a 20-line instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall of a command during hold is exercised directly.
module tb_timed_decoder;

    logic        clk;
    logic        rst;

    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [4:0]  in_sel;
    logic [7:0]  in_hold;
    logic [31:0] out;
    logic        busy;
    logic        err;

    logic        b_clear;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_mode;
    logic [4:0]  b_sel;
    logic [7:0]  b_hold;
    logic [19:0] b_out;
    logic        b_busy;
    logic        b_err;

    int checks = 0;
    int errors = 0;

    timed_decoder #(.INPUT_SIZE(5), .OUT_WIDTH(32), .HOLD_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_sel   (in_sel),
        .in_hold  (in_hold),
        .out      (out),
        .busy     (busy),
        .err      (err)
    );

    timed_decoder #(.INPUT_SIZE(5), .OUT_WIDTH(20), .HOLD_WIDTH(8)) dut20 (
        .clk      (clk),
        .rst      (rst),
        .clear    (b_clear),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_mode  (b_mode),
        .in_sel   (b_sel),
        .in_hold  (b_hold),
        .out      (b_out),
        .busy     (b_busy),
        .err      (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic [1:0] m, input logic [4:0] s, input logic [7:0] h);
        in_valid = v;
        in_mode  = m;
        in_sel   = s;
        in_hold  = h;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        cmd(1'b0, 2'd0, 5'd0, 8'd0);
        b_clear = 1'b0; b_valid = 1'b0; b_mode = 2'd0; b_sel = 5'd0; b_hold = 8'd0;
        tick();
        tick();
        chk("rst_out",  64'(out),  64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err",  64'(err),  64'h0);

        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(in_ready), 64'h1);
        chk("idle_out",   64'(out),      64'h0);

        // LEVEL sel 3, then sel 0
        cmd(1'b1, 2'd0, 5'd3, 8'd0);
        tick();
        chk("lvl3_out",   64'(out),      64'h8);
        chk("lvl3_busy",  64'(busy),     64'h1);
        chk("lvl3_ready", 64'(in_ready), 64'h1);
        in_valid = 1'b0;
        tick();
        chk("lvl3_latched", 64'(out), 64'h8);
        cmd(1'b1, 2'd0, 5'd0, 8'd0);
        tick();
        chk("lvl0_out", 64'(out), 64'h1);

        // Three back-to-back PULSEs on line 31
        cmd(1'b1, 2'd1, 5'd31, 8'd0);
        tick();
        chk("pulse1_out", 64'(out),      64'h8000_0000);
        chk("pulse1_rdy", 64'(in_ready), 64'h1);
        tick();
        chk("pulse2_out", 64'(out), 64'h8000_0000);
        tick();
        chk("pulse3_out", 64'(out), 64'h8000_0000);
        in_valid = 1'b0;
        tick();
        chk("pulse_end_out",  64'(out),  64'h0);
        chk("pulse_end_busy", 64'(busy), 64'h0);

        // HOLD sel 5 for 5 cycles with a LEVEL sel 7 stalled behind it
        cmd(1'b1, 2'd2, 5'd5, 8'd4);
        tick();
        chk("hold_c1_out", 64'(out),      64'h20);
        chk("hold_c1_rdy", 64'(in_ready), 64'h0);
        cmd(1'b1, 2'd0, 5'd7, 8'd0);
        tick();
        chk("hold_c2_out", 64'(out),      64'h20);
        chk("hold_c2_rdy", 64'(in_ready), 64'h0);
        tick();
        chk("hold_c3_out", 64'(out),      64'h20);
        chk("hold_c3_rdy", 64'(in_ready), 64'h0);
        tick();
        chk("hold_c4_out", 64'(out),      64'h20);
        chk("hold_c4_rdy", 64'(in_ready), 64'h0);
        tick();
        chk("hold_c5_out", 64'(out),      64'h20);
        chk("hold_c5_rdy", 64'(in_ready), 64'h1);
        tick();
        chk("stalled_lvl_out", 64'(out),  64'h80);
        chk("stalled_lvl_busy", 64'(busy), 64'h1);
        in_valid = 1'b0;

        // SCAN from line 30, dwell 2 cycles, wrap past 31
        cmd(1'b1, 2'd3, 5'd30, 8'd1);
        tick();
        in_valid = 1'b0;
        chk("scan_b30_a", 64'(out), 64'h4000_0000);
        tick();
        chk("scan_b30_b", 64'(out), 64'h4000_0000);
        tick();
        chk("scan_b31_a", 64'(out), 64'h8000_0000);
        chk("scan_ready", 64'(in_ready), 64'h1);
        tick();
        chk("scan_b31_b", 64'(out), 64'h8000_0000);
        tick();
        chk("scan_wrap_b0", 64'(out), 64'h1);
        clear = 1'b1;
        #1;
        chk("clear_ready", 64'(in_ready), 64'h0);
        tick();
        clear = 1'b0;
        chk("clear_out",  64'(out),  64'h0);
        chk("clear_busy", 64'(busy), 64'h0);

        // Reset in the middle of a HOLD
        cmd(1'b1, 2'd2, 5'd2, 8'd10);
        tick();
        in_valid = 1'b0;
        chk("hold2_out", 64'(out), 64'h4);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_hold_out",  64'(out),  64'h0);
        chk("rst_hold_busy", 64'(busy), 64'h0);
        chk("rst_hold_err",  64'(err),  64'h0);
        rst = 1'b0;
        tick();

        // 20-line instance: out-of-range select from S_LEVEL
        b_valid = 1'b1; b_mode = 2'd0; b_sel = 5'd3;
        tick();
        chk("b_lvl3_out", 64'(b_out), 64'h8);
        chk("b_lvl3_err", 64'(b_err), 64'h0);
        b_sel = 5'd25;
        tick();
        b_valid = 1'b0;
        chk("b_oor_err",  64'(b_err),  64'h1);
        chk("b_oor_out",  64'(b_out),  64'h0);
        chk("b_oor_busy", 64'(b_busy), 64'h0);
        tick();
        chk("b_err_once", 64'(b_err), 64'h0);

        // 20-line scan wraps bit 19 to bit 0
        b_valid = 1'b1; b_mode = 2'd3; b_sel = 5'd19; b_hold = 8'd0;
        tick();
        b_valid = 1'b0;
        chk("b_scan_b19", 64'(b_out), 64'h8_0000);
        tick();
        chk("b_scan_wrap", 64'(b_out), 64'h1);
        tick();
        chk("b_scan_b1", 64'(b_out), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
